// File: rtl/ldext_pipe.sv
// Registered load-data extract/extend stage: picks a byte/half/word/dword field
// out of a memory word, sign- or zero-extends it, flags illegal accesses.
module ldext_pipe #(
  parameter int M    = 32,
  parameter int CNTW = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [M-1:0]            i_data,
  input  logic [$clog2(M/8)-1:0]  i_offs,
  input  logic [1:0]              i_size,
  input  logic                    i_unsigned,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [M-1:0]            o_data,
  output logic                    o_misalign,
  output logic [CNTW-1:0]         o_err_cnt
);

  localparam int MAXSZ = $clog2(M/8);
  localparam int IW    = $clog2(M);

  logic          accept;
  logic          bad;
  logic          sgn;
  logic [IW-1:0] sidx;
  logic [M-1:0]  shifted;
  logic [M-1:0]  mask;
  logic [M-1:0]  ext_data;
  int            width;
  int            offs;

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;

  // Shift the addressed field down to bit 0, then mask it and fill the upper
  // bits; a full-width access leaves mask all ones so the word passes through.
  always_comb begin
    width    = 8 << i_size;
    offs     = int'(i_offs);
    bad      = (int'(i_size) > MAXSZ)
            || ((offs & ((1 << i_size) - 1)) != 0)
            || ((offs * 8 + width) > M);
    shifted  = i_data >> {i_offs, 3'b000};
    mask     = ~({M{1'b1}} << width);
    sidx     = IW'(width - 1);
    sgn      = shifted[sidx];
    ext_data = '0;
    if (!bad) begin
      ext_data = (shifted & mask) | ((sgn && !i_unsigned) ? ~mask : '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_misalign <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      if (accept) begin
        o_valid    <= 1'b1;
        o_data     <= ext_data;
        o_misalign <= bad;
        if (bad && (o_err_cnt != {CNTW{1'b1}})) begin
          o_err_cnt <= o_err_cnt + 1'b1;
        end
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ldext_pipe.sv
// Directed bench for ldext_pipe: a 32-bit/8-bit-counter instance for the main
// features and a 64-bit/2-bit-counter instance for saturation and dword access.
module tb_ldext_pipe;

  logic clk;
  logic rst;

  logic        a_valid, a_oready, a_ovalid, a_iready, a_uns, a_mis;
  logic [31:0] a_data, a_odata;
  logic [1:0]  a_offs, a_size;
  logic [7:0]  a_cnt;

  logic        b_valid, b_oready, b_ovalid, b_iready, b_uns, b_mis;
  logic [63:0] b_data, b_odata;
  logic [2:0]  b_offs;
  logic [1:0]  b_size;
  logic [1:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  ldext_pipe #(.M(32), .CNTW(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_oready),
    .i_data(a_data), .i_offs(a_offs), .i_size(a_size), .i_unsigned(a_uns),
    .o_valid(a_ovalid), .i_ready(a_iready), .o_data(a_odata),
    .o_misalign(a_mis), .o_err_cnt(a_cnt)
  );

  ldext_pipe #(.M(64), .CNTW(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_oready),
    .i_data(b_data), .i_offs(b_offs), .i_size(b_size), .i_unsigned(b_uns),
    .o_valid(b_ovalid), .i_ready(b_iready), .o_data(b_odata),
    .o_misalign(b_mis), .o_err_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle accept on instance A; outputs are settled #1 after the edge.
  task automatic send_a(input logic [31:0] d, input logic [1:0] o,
                        input logic [1:0] s, input logic u);
    a_data = d; a_offs = o; a_size = s; a_uns = u; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [63:0] d, input logic [2:0] o,
                        input logic [1:0] s, input logic u);
    b_data = d; b_offs = o; b_size = s; b_uns = u; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 0; a_iready = 1; a_data = '0; a_offs = '0; a_size = '0; a_uns = 0;
    b_valid = 0; b_iready = 1; b_data = '0; b_offs = '0; b_size = '0; b_uns = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0h expected 0", a_ovalid); end
    checks++; if (a_odata !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00000000", a_odata); end
    checks++; if (a_mis !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign: got %0h expected 0", a_mis); end
    checks++; if (a_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", a_cnt); end
    checks++; if (a_oready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0h expected 1", a_oready); end
    checks++; if (b_ovalid !== 1'b0 || b_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_b: got valid=%0h cnt=%0d expected valid=0 cnt=0", b_ovalid, b_cnt); end
  endtask

  task automatic test_signed_byte();
    send_a(32'h1234_80FF, 2'd1, 2'd0, 1'b0);
    checks++; if (a_ovalid !== 1'b1) begin errors++; $display("[TB] FAIL sbyte_valid: got %0h expected 1", a_ovalid); end
    checks++; if (a_odata !== 32'hFFFF_FF80) begin errors++; $display("[TB] FAIL sbyte_data: got %h expected ffffff80", a_odata); end
    checks++; if (a_mis !== 1'b0) begin errors++; $display("[TB] FAIL sbyte_misalign: got %0h expected 0", a_mis); end
  endtask

  task automatic test_unsigned();
    send_a(32'h1234_80FF, 2'd1, 2'd0, 1'b1);
    checks++; if (a_odata !== 32'h0000_0080) begin errors++; $display("[TB] FAIL ubyte_data: got %h expected 00000080", a_odata); end
    send_a(32'h8001_0000, 2'd2, 2'd1, 1'b0);
    checks++; if (a_odata !== 32'hFFFF_8001) begin errors++; $display("[TB] FAIL shalf_data: got %h expected ffff8001", a_odata); end
    send_a(32'h8765_4321, 2'd0, 2'd2, 1'b0);
    checks++; if (a_odata !== 32'h8765_4321) begin errors++; $display("[TB] FAIL word_data: got %h expected 87654321", a_odata); end
    @(posedge clk); #1;
    checks++; if (a_ovalid !== 1'b0 || a_odata !== 32'h8765_4321) begin errors++; $display("[TB] FAIL drain: got valid=%0h data=%h expected valid=0 data=87654321", a_ovalid, a_odata); end
  endtask

  task automatic test_misalign();
    send_a(32'hFFFF_FFFF, 2'd1, 2'd1, 1'b0);
    checks++; if (a_odata !== 32'h0 || a_mis !== 1'b1) begin errors++; $display("[TB] FAIL mis_half: got data=%h mis=%0h expected data=00000000 mis=1", a_odata, a_mis); end
    checks++; if (a_cnt !== 8'd1) begin errors++; $display("[TB] FAIL mis_cnt1: got %0d expected 1", a_cnt); end
    send_a(32'hFFFF_FFFF, 2'd0, 2'd3, 1'b0);
    checks++; if (a_mis !== 1'b1 || a_cnt !== 8'd2) begin errors++; $display("[TB] FAIL mis_dword: got mis=%0h cnt=%0d expected mis=1 cnt=2", a_mis, a_cnt); end
    send_a(32'hAB00_0000, 2'd3, 2'd0, 1'b0);
    checks++; if (a_odata !== 32'hFFFF_FFAB || a_mis !== 1'b0 || a_cnt !== 8'd2) begin errors++; $display("[TB] FAIL top_byte: got data=%h mis=%0h cnt=%0d expected data=ffffffab mis=0 cnt=2", a_odata, a_mis, a_cnt); end
  endtask

  task automatic test_back_to_back();
    send_a(32'h0000_00AB, 2'd0, 2'd0, 1'b1);
    checks++; if (a_ovalid !== 1'b1 || a_odata !== 32'h0000_00AB) begin errors++; $display("[TB] FAIL bp_a: got valid=%0h data=%h expected valid=1 data=000000ab", a_ovalid, a_odata); end
    a_iready = 1'b0;
    a_data = 32'h0000_CD00; a_offs = 2'd1; a_size = 2'd0; a_uns = 1'b1; a_valid = 1'b1;
    #1;
    checks++; if (a_oready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low: got %0h expected 0", a_oready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (a_ovalid !== 1'b1 || a_odata !== 32'h0000_00AB || a_oready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold%0d: got valid=%0h data=%h ready=%0h expected valid=1 data=000000ab ready=0", i, a_ovalid, a_odata, a_oready); end
    end
    a_iready = 1'b1;
    #1;
    checks++; if (a_oready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_high: got %0h expected 1", a_oready); end
    @(posedge clk); #1;
    a_valid = 1'b0;
    checks++; if (a_ovalid !== 1'b1 || a_odata !== 32'h0000_00CD) begin errors++; $display("[TB] FAIL bp_b: got valid=%0h data=%h expected valid=1 data=000000cd", a_ovalid, a_odata); end
    @(posedge clk); #1;
    checks++; if (a_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain: got %0h expected 0", a_ovalid); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      send_b(64'h0, 3'd1, 2'd1, 1'b0);
      checks++; if (b_cnt !== exp_cnt[i] || b_mis !== 1'b1) begin errors++; $display("[TB] FAIL sat%0d: got cnt=%0d mis=%0h expected cnt=%0d mis=1", i, b_cnt, b_mis, exp_cnt[i]); end
    end
  endtask

  task automatic test_full_dword();
    send_b(64'h8000_0000_0000_0001, 3'd0, 2'd3, 1'b0);
    checks++; if (b_odata !== 64'h8000_0000_0000_0001 || b_mis !== 1'b0) begin errors++; $display("[TB] FAIL dword_s: got data=%h mis=%0h expected data=8000000000000001 mis=0", b_odata, b_mis); end
    send_b(64'h8000_0000_0000_0001, 3'd0, 2'd3, 1'b1);
    checks++; if (b_odata !== 64'h8000_0000_0000_0001) begin errors++; $display("[TB] FAIL dword_u: got %h expected 8000000000000001", b_odata); end
    send_b(64'h8000_0001_0000_0000, 3'd4, 2'd2, 1'b0);
    checks++; if (b_odata !== 64'hFFFF_FFFF_8000_0001) begin errors++; $display("[TB] FAIL word_hi: got %h expected ffffffff80000001", b_odata); end
  endtask

  task automatic test_mid_reset();
    send_a(32'h1122_3344, 2'd0, 2'd2, 1'b0);
    a_iready = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_ovalid !== 1'b1 || a_cnt !== 8'd2) begin errors++; $display("[TB] FAIL pre_reset: got valid=%0h cnt=%0d expected valid=1 cnt=2", a_ovalid, a_cnt); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (a_ovalid !== 1'b0 || a_odata !== 32'h0 || a_mis !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out: got valid=%0h data=%h mis=%0h expected valid=0 data=00000000 mis=0", a_ovalid, a_odata, a_mis); end
    checks++; if (a_cnt !== 8'd0 || a_oready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_cnt: got cnt=%0d ready=%0h expected cnt=0 ready=1", a_cnt, a_oready); end
  endtask

  initial begin
    test_reset();
    test_signed_byte();
    test_unsigned();
    test_misalign();
    test_back_to_back();
    test_saturation();
    test_full_dword();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldext_pipe.md
Name: ldext_pipe

Overview:
Registered load-data extract-and-extend stage, the parametrised successor of the combinational N-to-M sign extender. It takes a full data word plus a byte offset and an access size, then selects the addressed byte, halfword, word or doubleword. It sign- or zero-extends the selected field to the full width. The block sits between the data-memory read port and register writeback, with one valid/ready pipeline register, misalignment detection and a saturating error counter.

Parameters:
M, 32, datapath width in bits; legal values 16, 32, 64.
CNTW, 8, width of the saturating misalignment error counter.

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_valid  input  1  upstream transaction valid
o_ready  output  1  block can accept upstream transaction
i_data  input  M  raw memory word
i_offs  input  $clog2(M/8)  byte offset of field within i_data
i_size  input  2  log2 of access bytes (0=byte,1=half,2=word,3=dword)
i_unsigned  input  1  1=zero-extend, 0=sign-extend
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_data  output  M  extracted, extended result
o_misalign  output  1  result flagged as illegal access
o_err_cnt  output  CNTW  saturating count of accepted misaligned transactions

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst is synchronous, active-high, and takes priority over all other events.
- Reset values: o_valid=0, o_data=0, o_misalign=0, o_err_cnt=0.
- Upstream handshake: o_ready = !o_valid || i_ready, combinational from i_ready. An accept happens in any cycle where i_valid && o_ready.
- Downstream handshake: a transfer happens in any cycle where o_valid && i_ready.
- Latency: on an accept, the result is registered and o_valid=1 next cycle. Throughput is 1 per cycle when i_ready is held high.
- Drain: a downstream transfer with no accept in the same cycle sets o_valid=0 next cycle. o_data and o_misalign keep their last values.
- Stall: while o_valid && !i_ready, o_data and o_misalign are held stable and no accept occurs. i_valid may toggle and i_data may change without effect.
- Field width: W = 8 << i_size.
- Illegal access: any of the following sets misalign=1 and data=0.
  - i_size > log2(M/8).
  - i_offs not a multiple of 2^i_size.
  - (i_offs*8 + W) > M.
- Legal access: field = i_data[i_offs*8 +: W]. Result = field in the low W bits. Upper M-W bits are all field[W-1] when i_unsigned=0, and all 0 when i_unsigned=1. misalign=0.
- Full-width access (W == M): passes i_data unchanged; i_unsigned has no effect.
- o_err_cnt: increments by 1 on each accept with misalign=1 and saturates at 2^CNTW-1. It is cleared only by reset.
- Simultaneous accept and downstream transfer: the new result replaces the old one and o_valid stays 1.
- Reset mid-operation: a pending result is discarded. o_valid=0 the next cycle regardless of i_ready, and o_err_cnt clears.
- No combinational path from i_data, i_offs, i_size or i_unsigned to any output. The only combinational path is i_ready -> o_ready.

Test Plan:
- Signed byte (M=32, i_ready=1): i_data=0x1234_80FF, i_offs=1, i_size=0, i_unsigned=0 -> next cycle o_valid=1, o_data=0xFFFF_FF80, o_misalign=0.
- Unsigned byte: same stimulus with i_unsigned=1 -> o_data=0x0000_0080. Then i_data=0x8001_0000, i_offs=2, i_size=1, signed -> o_data=0xFFFF_8001.
- Misalignment: i_offs=1, i_size=1 -> o_data=0, o_misalign=1, o_err_cnt=1. Then i_offs=0, i_size=3 at M=32 -> o_misalign=1, o_err_cnt=2.
- Backpressure sequence:
  - Accept A=0x0000_00AB byte unsigned.
  - Hold i_ready=0 for 3 cycles with i_valid=1 and B presented -> o_ready=0, o_data=0x0000_00AB stable, B not accepted.
  - Raise i_ready -> A transfers, B accepted the same cycle, B output next cycle.
- Saturation and full word: CNTW=2, 5 consecutive misaligned accepts -> o_err_cnt sequence 1,2,3,3,3. With M=64, i_size=3, i_offs=0, i_data=0x8000_0000_0000_0001 -> o_data equal to i_data.
- Reset mid-operation: assert i_rst for 1 cycle while o_valid=1, i_ready=0, o_err_cnt=2 -> next cycle o_valid=0, o_data=0, o_misalign=0, o_err_cnt=0, o_ready=1.
